// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall hold, bubble flush, valid bit,
// Tnew countdown, wr normalisation and a saturating stall counter. Optional: PIPE_STAGE_REQ_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 96,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned WR_W        = 5,
  parameter int unsigned TNEW_W      = 3,
  parameter bit          TNEW_DEC    = 1'b1,
  parameter logic [31:0] PC_RESET    = 32'h3000,
  parameter logic [31:0] EXC_PC      = 32'h4180,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
`ifdef PIPE_STAGE_REQ_EN
  input  logic                   req,
`endif
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [WR_W-1:0]        in_wr,
  input  logic                   in_regwrite,
  input  logic [TNEW_W-1:0]      in_tnew,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [WR_W-1:0]        out_wr,
  output logic                   out_regwrite,
  output logic [TNEW_W-1:0]      out_tnew,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] out_stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [WR_W-1:0]   wr;
    logic              regwrite;
    logic [TNEW_W-1:0] tnew;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t                  slot_q, slot_d;
  slot_t                  bubble, exc_bubble, loaded;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   req_hit;

`ifdef PIPE_STAGE_REQ_EN
  assign req_hit = req;
`else
  assign req_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    bubble        = '0;
    bubble.pc     = PC_RESET;
    exc_bubble    = '0;
    exc_bubble.pc = EXC_PC;

    // An empty upstream slot still advances the PC so traces stay aligned.
    loaded    = '0;
    loaded.pc = in_pc;
    if (in_valid) begin
      loaded.valid    = 1'b1;
      loaded.regwrite = in_regwrite;
      loaded.wr       = in_regwrite ? in_wr : '0;
      loaded.ctrl     = in_ctrl;
      loaded.data     = in_data;
      if (TNEW_DEC)
        loaded.tnew = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
      else
        loaded.tnew = in_tnew;
    end

    slot_d      = slot_q;
    stall_cnt_d = stall_cnt_q;
    if (req_hit) begin
      slot_d = exc_bubble;
    end else if (flush) begin
      slot_d = bubble;
    end else if (!en) begin
      // Only cycles spent holding a real instruction count as stalls.
      if (slot_q.valid && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      slot_d = loaded;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= bubble;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid     = slot_q.valid;
  assign out_pc        = slot_q.pc;
  assign out_wr        = slot_q.wr;
  assign out_regwrite  = slot_q.regwrite;
  assign out_tnew      = slot_q.tnew;
  assign out_ctrl      = slot_q.ctrl;
  assign out_data      = slot_q.data;
  assign out_stall_cnt = stall_cnt_q;

endmodule
